// File: rtl/l1_dcache.sv
// Direct-mapped write-back L1 data cache: 128-bit lines, 16-bit CPU port, zero-latency hits.
// Define L1_DCACHE_STATS_EN to build the saturating access/miss counters; otherwise both read as 0.
module l1_dcache #(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         dcache_hit,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  access_count,
  output logic [15:0]  miss_count
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = 12 - INDEX_W;
  localparam int unsigned LINE_W  = 128;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [INDEX_W-1:0]  miss_index;
  logic [TAG_W-1:0]    miss_tag;

  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic [2:0]          word_sel;
  logic                req;
  logic                in_idle;
  logic                hit_c;
  logic                miss_start;
  logic                victim_dirty;
  logic [LINE_W-1:0]   line_rd;
  logic [LINE_W-1:0]   wr_line;
  logic                addr_unused;

  assign req_index    = mem_address[4 +: INDEX_W];
  assign req_tag      = mem_address[15 -: TAG_W];
  assign word_sel     = mem_address[3:1];
  assign addr_unused  = mem_address[0];
  assign req          = mem_read | mem_write;
  assign in_idle      = rst_n && (state == IDLE);
  assign line_rd      = data_q[req_index];
  assign hit_c        = in_idle && req && valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign miss_start   = in_idle && req && !hit_c;
  assign victim_dirty = valid_q[req_index] && dirty_q[req_index];

  // Byte-lane merge of the write data into the addressed line
  always_comb begin
    wr_line = line_rd;
    for (int b = 0; b < 2; b++) begin
      if (mem_byte_enable[b]) wr_line[{word_sel, 1'(b), 3'b000} +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // CPU side answers combinationally on a hit; read data is the pre-write word
  always_comb begin
    mem_resp   = hit_c;
    dcache_hit = hit_c;
    mem_rdata  = hit_c ? line_rd[{word_sel, 4'b0000} +: 16] : 16'h0000;
  end

  // Memory side is decoded from the state register and gated off during reset
  always_comb begin
    pmem_write   = rst_n && (state == WRITEBACK);
    pmem_read    = rst_n && (state == ALLOCATE);
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    if (pmem_write) begin
      pmem_address = {tag_q[miss_index], miss_index, 4'b0000};
      pmem_wdata   = data_q[miss_index];
    end else if (pmem_read) begin
      pmem_address = {miss_tag, miss_index, 4'b0000};
    end
  end

  // Controller state and per-line valid/dirty bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_c && mem_write) begin
            if (mem_byte_enable != 2'b00) dirty_q[req_index] <= 1'b1;
          end else if (miss_start) begin
            state <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            valid_q[miss_index] <= 1'b1;
            dirty_q[miss_index] <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays and the latched miss address carry no reset
  always_ff @(posedge clk) begin
    if (hit_c && mem_write) data_q[req_index] <= wr_line;
    if (pmem_read && pmem_resp) begin
      data_q[miss_index] <= pmem_rdata;
      tag_q[miss_index]  <= miss_tag;
    end
    if (miss_start) begin
      miss_index <= req_index;
      miss_tag   <= req_tag;
    end
  end

`ifdef L1_DCACHE_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      access_count <= 16'h0000;
      miss_count   <= 16'h0000;
    end else begin
      if (hit_c && (access_count != 16'hFFFF)) access_count <= access_count + 16'd1;
      if (miss_start && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign access_count = 16'h0000;
  assign miss_count   = 16'h0000;
`endif

endmodule
